// File: rtl/pipe_regfile.sv
// pipe_regfile: parametrised GPR file with two combinational read ports,
// two synchronous write ports (A = ALU writeback, B = load writeback) and a
// per-register busy scoreboard used by the pipeline controller for RAW
// hazard detection. Port B has priority when both ports hit one register.
// Optional feature macro: PIPE_REGFILE_BYPASS_EN (write-to-read forwarding
// of data and busy-clear into the same cycle).
// There is no handshake: every input is sampled on each rising clock edge,
// and the enables qualify it.
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wa_ok;
    logic              wb_ok;

    // Hard-wired zero register: only when enabled by parameter.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A write is effective unless it targets the hard-wired zero register.
    always_comb begin
        wa_ok = wa_en && !is_zero(wa_addr);
        wb_ok = wb_en && !is_zero(wb_addr);
    end

    // Read data for one port, with optional same-cycle forwarding (B over A).
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = regs_q[ra];
`ifdef PIPE_REGFILE_BYPASS_EN
        if (wa_ok && (wa_addr == ra)) v = wa_data;
        if (wb_ok && (wb_addr == ra)) v = wb_data;
`endif
        if (is_zero(ra)) v = '0;
        return v;
    endfunction

    // Busy bit for one port; with forwarding, a completing write hides the
    // bit unless a new producer is issued to the same register this cycle.
    function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
        logic b;
        b = sb_q[ra];
`ifdef PIPE_REGFILE_BYPASS_EN
        if (((wa_en && (wa_addr == ra)) || (wb_en && (wb_addr == ra))) &&
            !(iss_en && (iss_addr == ra)))
            b = 1'b0;
`endif
        if (is_zero(ra)) b = 1'b0;
        return b;
    endfunction

    // Next-state storage: port A first so port B overrides on a collision.
    always_comb begin
        regs_d = regs_q;
        if (wa_ok) regs_d[wa_addr] = wa_data;
        if (wb_ok) regs_d[wb_addr] = wb_data;
    end

    // Next-state scoreboard: completions clear, then issue sets (set wins).
    always_comb begin
        sb_d = sb_q;
        if (wa_en)  sb_d[wa_addr]  = 1'b0;
        if (wb_en)  sb_d[wb_addr]  = 1'b0;
        if (iss_en) sb_d[iss_addr] = 1'b1;
        if (ZERO_REG != 0) sb_d[0] = 1'b0;
    end

    // Popcount of the next scoreboard so busy_cnt lines up with the bits.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(sb_d[i]);
        end
    end

    // Storage flops, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Scoreboard and busy counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    // Read ports; forced to zero while reset is held so forwarding is masked.
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!rst) begin
            rd1   = read_data(ra1);
            rd2   = read_data(ra2);
            busy1 = read_busy(ra1);
            busy2 = read_busy(ra2);
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Bench for pipe_regfile: default-parameter instance checked every cycle
// against a behavioural model plus literal spot checks, and a small
// DATA_W=16 / ADDR_W=3 / ZERO_REG=0 instance checked with literals.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra1 = '0, ra2 = '0;
    logic [31:0] rd1, rd2;
    logic        busy1, busy2;
    logic        wa_en = 1'b0, wb_en = 1'b0, iss_en = 1'b0;
    logic [4:0]  wa_addr = '0, wb_addr = '0, iss_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic [5:0]  busy_cnt;

    logic [2:0]  s_ra1 = '0, s_ra2 = '0;
    logic [15:0] s_rd1, s_rd2;
    logic        s_busy1, s_busy2;
    logic        s_wa_en = 1'b0, s_wb_en = 1'b0, s_iss_en = 1'b0;
    logic [2:0]  s_wa_addr = '0, s_wb_addr = '0, s_iss_addr = '0;
    logic [15:0] s_wa_data = '0, s_wb_data = '0;
    logic [3:0]  s_busy_cnt;

    int errors = 0;
    int checks = 0;

`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    pipe_regfile dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    pipe_regfile #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
        .clk(clk), .rst(rst), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
        .busy1(s_busy1), .busy2(s_busy2),
        .wa_en(s_wa_en), .wa_addr(s_wa_addr), .wa_data(s_wa_data),
        .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
        .iss_en(s_iss_en), .iss_addr(s_iss_addr), .busy_cnt(s_busy_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- behavioural model (default instance, ZERO_REG=1) ----
    logic [31:0] m_mem [32];
    bit          m_sb  [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_sb[i]  = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0;
                m_sb[i]  = 1'b0;
            end
        end else begin
            if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
            if (wa_en) m_sb[wa_addr] = 1'b0;
            if (wb_en) m_sb[wb_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_sb[iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (rst || ra == 0) return 32'd0;
        if (BYP && wb_en && wb_addr == ra) return wb_data;
        if (BYP && wa_en && wa_addr == ra) return wa_data;
        return m_mem[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (rst || ra == 0) return 1'b0;
        if (BYP && ((wa_en && wa_addr == ra) || (wb_en && wb_addr == ra)) &&
            !(iss_en && iss_addr == ra)) return 1'b0;
        return m_sb[ra];
    endfunction

    function automatic logic [5:0] exp_cnt();
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(m_sb[i]);
        return c;
    endfunction

    // ---------------- scoreboard / checks ---------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("rd1",      rd1,              exp_rd(ra1));
        chk("rd2",      rd2,              exp_rd(ra2));
        chk("busy1",    32'(busy1),       32'(exp_busy(ra1)));
        chk("busy2",    32'(busy2),       32'(exp_busy(ra2)));
        chk("busy_cnt", 32'(busy_cnt),    32'(exp_cnt()));
    end

    // ---------------- driver tasks ----------------------------------------
    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
        s_wa_en = 1'b0; s_wb_en = 1'b0; s_iss_en = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [31:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic write_b(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    // ---------------- directed stimulus -----------------------------------
    initial begin
        // reset state
        idle();
        cyc(); cyc();
        ra1 = 5'd3;
        #1;
        chk("reset_rd1", rd1, 32'd0);
        chk("reset_cnt", 32'(busy_cnt), 32'd0);
        rst = 1'b0;
        cyc();

        // reset mid-operation: r5 written and issued, then rst between edges
        write_a(5'd5, 32'hDEADBEEF); issue(5'd5);
        cyc();
        iss_en = 1'b0;
        ra1 = 5'd5;
        #1;
        chk("r5_written", rd1, 32'hDEADBEEF);
        chk("r5_cnt", 32'(busy_cnt), 32'd1);
        wa_data = 32'h12345678;
        #1 rst = 1'b1;
        #1;
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_write_lost", rd1, 32'd0);
        cyc();

        // dual-write collision and zero register
        write_a(5'd7, 32'h11); write_b(5'd7, 32'h22);
        cyc();
        idle();
        ra1 = 5'd7;
        #1;
        chk("collision_b_wins", rd1, 32'h22);
        write_a(5'd0, 32'hFFFFFFFF); write_b(5'd0, 32'hEEEEEEEE); issue(5'd0);
        cyc();
        idle();
        ra1 = 5'd0;
        #1;
        chk("r0_reads_zero", rd1, 32'd0);
        chk("r0_not_busy", 32'(busy1), 32'd0);
        chk("r0_cnt", 32'(busy_cnt), 32'd0);

        // scoreboard: issue r3, r9 on consecutive cycles, then complete r3
        issue(5'd3);
        cyc();
        issue(5'd9);
        #1;
        chk("cnt_after_r3", 32'(busy_cnt), 32'd1);
        cyc();
        idle();
        #1;
        chk("cnt_after_r9", 32'(busy_cnt), 32'd2);
        write_a(5'd3, 32'h33);
        cyc();
        idle();
        ra1 = 5'd3; ra2 = 5'd9;
        #1;
        chk("r3_busy_clr", 32'(busy1), 32'd0);
        chk("r9_busy_hold", 32'(busy2), 32'd1);
        chk("cnt_after_clr", 32'(busy_cnt), 32'd1);

        // set-over-clear on r4
        ra1 = 5'd0; ra2 = 5'd0;
        issue(5'd4);
        cyc();
        write_b(5'd4, 32'h44); issue(5'd4);
        cyc();
        idle();
        ra1 = 5'd4;
        #1;
        chk("r4_data", rd1, 32'h44);
        chk("r4_busy_kept", 32'(busy1), 32'd1);
        chk("r4_cnt", 32'(busy_cnt), 32'd2);

        // forwarding behaviour on r12 (previously zero, issued busy)
        issue(5'd12);
        cyc();
        idle();
        write_a(5'd12, 32'hCAFE0001);
        ra2 = 5'd12;
        #1;
        chk("byp_rd2", rd2, BYP ? 32'hCAFE0001 : 32'd0);
        chk("byp_busy2", 32'(busy2), BYP ? 32'd0 : 32'd1);
        cyc();
        idle();
        #1;
        chk("r12_next", rd2, 32'hCAFE0001);
        chk("r12_busy_next", 32'(busy2), 32'd0);

        // compact vector table: disjoint dual writes, model checks each cycle
        for (int i = 1; i <= 8; i++) begin
            write_a(5'(i + 16), 32'hA000_0000 + 32'(i));
            write_b(5'(i + 20), 32'hB000_0000 + 32'(i));
            issue(5'(i + 8));
            ra1 = 5'(i + 15);
            ra2 = 5'(i + 19);
            cyc();
        end
        idle();
        ra1 = 5'd17; ra2 = 5'd28;
        #1;
        chk("tbl_r17", rd1, 32'hA000_0001);
        chk("tbl_r28", rd2, 32'hB000_0008);
        cyc();

        // parameter sweep instance: 8 regs incl. r0 with 0xA5A5
        for (int i = 0; i < 8; i++) begin
            s_wa_en = 1'b1; s_wa_addr = 3'(i); s_wa_data = 16'hA5A5;
            cyc();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            s_ra1 = 3'(i);
            #1;
            chk($sformatf("s_r%0d", i), 32'(s_rd1), 32'h0000A5A5);
        end
        for (int i = 0; i < 8; i++) begin
            s_iss_en = 1'b1; s_iss_addr = 3'(i);
            cyc();
        end
        idle();
        s_ra1 = 3'd0;
        #1;
        chk("s_cnt_full", 32'(s_busy_cnt), 32'd8);
        chk("s_r0_busy", 32'(s_busy1), 32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised general-purpose register file for the pipelined core: two asynchronous read ports, two synchronous write ports (ALU writeback and load writeback), and a per-register busy scoreboard for RAW hazard detection. Reset clears every register and every busy bit. It sits between decode (reads, issue) and writeback (writes), replacing the fixed 32x32 single-write file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count NREG = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data, combinational from ra1/ra2
- busy1, busy2  out  1  scoreboard bit of ra1/ra2
- wa_en, wa_addr, wa_data  in  1/ADDR_W/DATA_W  write port A (ALU writeback)
- wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write port B (load writeback)
- iss_en, iss_addr  in  1/ADDR_W  issue: mark iss_addr busy (pending producer)
- busy_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- Storage: NREG x DATA_W flops; no RAM inference required.
- Writes: on posedge clk, each enabled port writes its address. Same address on both ports: port B wins. ZERO_REG=1: writes to address 0 dropped.
- Reads: rd1/rd2 = storage[ra] (modified by bypass, see Configuration). ZERO_REG=1 and ra=0: read 0.
- Scoreboard, per register i at posedge: clear if (wa_en & wa_addr==i) or (wb_en & wb_addr==i); then set if iss_en & iss_addr==i. Set overrides clear same cycle (new producer issued as old completes). ZERO_REG=1: bit 0 constant 0.
- busy1/busy2 = scoreboard[ra1]/[ra2], combinational.
- busy_cnt: popcount of scoreboard, registered (reflects state after the edge, valid one cycle after the change, same cycle as scoreboard bits).
- Write to a non-busy register is legal; data written, scoreboard unchanged unless issue targets it.
- Hazard/stall decision belongs to the pipeline controller; this block only reports.

## Timing
- Reset (async, any time including mid-write): all registers 0, all busy bits 0, busy_cnt 0; rd1/rd2 read 0, busy1/busy2 0 while rst high. Writes and issues during rst ignored.
- Write latency: data visible on rd at the first cycle after the write edge (0 cycles with bypass).
- Issue latency: busy visible the cycle after iss_en.
- Write clearing busy: busy drops the cycle after the write edge (same cycle with bypass, unless concurrently issued).
- No handshake; all inputs sampled every posedge, enables qualify.

## Configuration
- Macro PIPE_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If ra matches an enabled write address (and ra!=0 when ZERO_REG=1), rd returns that write's data (port B over port A) in the same cycle; busy for that ra returns 0 unless iss_en & iss_addr==ra in the same cycle.
- Undefined: rd and busy are pure storage/scoreboard reads; written values and cleared busy appear one cycle later.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, assert rst between edges -> rd1 with ra1=5 reads 0 immediately, busy_cnt=0, write in rst cycle lost.
- Dual write collision: wa and wb both to r7, wa_data=0x11, wb_data=0x22 -> r7=0x22 next cycle; ZERO_REG=1 writes to r0 -> r0 reads 0.
- Scoreboard: issue r3, r9 on consecutive cycles -> busy_cnt 1 then 2; wa writes r3 -> busy on ra=3 drops, busy_cnt=1.
- Set-over-clear: same cycle wb writes r4 and iss_addr=4 -> r4 holds new data, busy stays 1, busy_cnt unchanged.
- Bypass (macro defined): wa_en, wa_addr=12, wa_data=0xCAFE0001, ra2=12 same cycle -> rd2=0xCAFE0001, busy2=0; macro undefined -> rd2 old value, then 0xCAFE0001 next cycle.
- Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> write/read all 8 regs incl. r0 with 0xA5A5, busy_cnt reaches 8 after issuing all.
